// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA DREQ/DACK channel arbiter.
package dma_arb_pkg;

  typedef enum logic {IDLE, GRANTED} arb_state_e;
  typedef enum logic {PRIO_FIXED = 1'b0, PRIO_ROTATE = 1'b1} prio_type_e;

  localparam int DEFAULT_NUM_CH = 4;

endpackage

// File: rtl/dma_prio_pick.sv
// Combinational priority picker: first eligible channel searching upward from
// startIdx (modulo NUM_CH) in rotating mode, or from channel 0 in fixed mode.
module dma_prio_pick
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   startIdx,
  input  prio_type_e        mode,
  output logic              found,
  output logic [CH_W-1:0]   index
);

  int base;
  int idx;

  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = 0;
    base  = (mode == PRIO_ROTATE) ? int'(startIdx) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Explicit wrap so non-power-of-two channel counts stay in range.
      idx = base + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        index = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DREQ/DACK channel arbiter with masking and fixed/rotating priority.
// Define DMA_ARB_DREQ_SYNC_EN to pass DREQ through a 2-flop synchronizer.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter  int NUM_CH = DEFAULT_NUM_CH,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskIn,
  input  logic              priorityType,
  input  logic              assertDACK,
  input  logic              releaseDACK,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantChannel
);

  arb_state_e        state;
  prio_type_e        grantMode;
  logic [CH_W-1:0]   rotPtr;
  logic [CH_W-1:0]   rotNext;
  logic [NUM_CH-1:0] dreqUse;
  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [CH_W-1:0]   pickIdx;

`ifdef DMA_ARB_DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreqMeta;
  logic [NUM_CH-1:0] dreqSync;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dreqMeta <= '0;
      dreqSync <= '0;
    end else begin
      dreqMeta <= DREQ;
      dreqSync <= dreqMeta;
    end
  end

  assign dreqUse = dreqSync;
`else
  assign dreqUse = DREQ;
`endif

  assign eligible = dreqUse & ~maskIn;
  assign rotNext  = (grantChannel == CH_W'(NUM_CH - 1)) ? '0 : grantChannel + CH_W'(1);

  dma_prio_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) uPick (
    .eligible (eligible),
    .startIdx (rotPtr),
    .mode     (prio_type_e'(priorityType)),
    .found    (found),
    .index    (pickIdx)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      grantMode    <= PRIO_FIXED;
      rotPtr       <= '0;
      DACK         <= '0;
      grantValid   <= 1'b0;
      grantChannel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (assertDACK && found) begin
            DACK         <= {{(NUM_CH-1){1'b0}}, 1'b1} << pickIdx;
            grantChannel <= pickIdx;
            grantValid   <= 1'b1;
            grantMode    <= prio_type_e'(priorityType);
            state        <= GRANTED;
          end
        end
        GRANTED: begin
          // Release wins over abort; the rotation follows the mode the grant was made in.
          if (releaseDACK) begin
            DACK       <= '0;
            grantValid <= 1'b0;
            state      <= IDLE;
            if (grantMode == PRIO_ROTATE) rotPtr <= rotNext;
          end else if (!assertDACK) begin
            DACK       <= '0;
            grantValid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter (4-channel and 5-channel instances).
module tb_dma_channel_arbiter;
  import dma_arb_pkg::*;

  logic       CLK, RESET;
  logic [3:0] DREQ, maskIn, DACK;
  logic       priorityType, assertDACK, releaseDACK, grantValid;
  logic [1:0] grantChannel;

  logic [4:0] DREQ5, mask5, DACK5;
  logic       prio5, assert5, release5, grantValid5;
  logic [2:0] grantChannel5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dack;
    logic [31:0] ch;
  } grant_t;
  grant_t sb[$];

  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskIn(maskIn),
    .priorityType(priorityType), .assertDACK(assertDACK), .releaseDACK(releaseDACK),
    .DACK(DACK), .grantValid(grantValid), .grantChannel(grantChannel)
  );

  dma_channel_arbiter #(.NUM_CH(5)) dut5 (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ5), .maskIn(mask5),
    .priorityType(prio5), .assertDACK(assert5), .releaseDACK(release5),
    .DACK(DACK5), .grantValid(grantValid5), .grantChannel(grantChannel5)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectGrant(input logic [31:0] dack, input logic [31:0] ch);
    grant_t g;
    g.dack = dack;
    g.ch   = ch;
    sb.push_back(g);
  endtask

  task automatic checkGrant(input string tag, input logic [31:0] dack,
                            input logic [31:0] ch, input logic vld);
    grant_t g;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed grant %0h with empty scoreboard expected none", tag, dack);
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk({tag, "_dack"}, dack, g.dack);
      chk({tag, "_ch"}, ch, g.ch);
      chk({tag, "_vld"}, 32'(vld), 32'd1);
    end
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, "_dack"}, 32'(DACK), 32'd0);
    chk({tag, "_vld"}, 32'(grantValid), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; DREQ = '0; maskIn = '0; priorityType = 1'b0;
    assertDACK = 1'b0; releaseDACK = 1'b0;
    DREQ5 = '0; mask5 = '0; prio5 = 1'b0; assert5 = 1'b0; release5 = 1'b0;
    #12;
    checkIdle("reset");
    chk("reset_ch", 32'(grantChannel), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    RESET = 1'b0;

    // Fixed priority: lowest index wins, grant holds while DREQ changes
    DREQ = 4'b1010; assertDACK = 1'b1;
    expectGrant(32'b0010, 1);
    step();
    checkGrant("fixed", 32'(DACK), 32'(grantChannel), grantValid);
    DREQ = 4'b1000;
    step();
    chk("fixed_hold", 32'(DACK), 32'b0010);
    DREQ = 4'b0000; releaseDACK = 1'b1;
    step();
    releaseDACK = 1'b0;
    checkIdle("fixed_rel");
    chk("fixed_rot", 32'(dut.rotPtr), 32'd0);

    // Rotating: ch2, release -> ptr 3, next grant ch3 after gap, then wrap to ch0
    priorityType = 1'b1; DREQ = 4'b0100;
    expectGrant(32'b0100, 2);
    step();
    checkGrant("rot_c2", 32'(DACK), 32'(grantChannel), grantValid);
    DREQ = 4'b1111; releaseDACK = 1'b1;
    step();
    releaseDACK = 1'b0;
    checkIdle("rot_gap1");
    chk("rot_ptr3", 32'(dut.rotPtr), 32'd3);
    expectGrant(32'b1000, 3);
    step();
    checkGrant("rot_c3", 32'(DACK), 32'(grantChannel), grantValid);
    releaseDACK = 1'b1;
    step();
    releaseDACK = 1'b0;
    checkIdle("rot_gap2");
    chk("rot_wrap", 32'(dut.rotPtr), 32'd0);
    expectGrant(32'b0001, 0);
    step();
    checkGrant("rot_c0", 32'(DACK), 32'(grantChannel), grantValid);
    DREQ = 4'b0000; releaseDACK = 1'b1;
    step();
    releaseDACK = 1'b0;
    chk("rot_ptr1", 32'(dut.rotPtr), 32'd1);

    // Masking
    priorityType = 1'b0; DREQ = 4'b0011; maskIn = 4'b0001;
    expectGrant(32'b0010, 1);
    step();
    checkGrant("mask", 32'(DACK), 32'(grantChannel), grantValid);
    DREQ = 4'b0000; releaseDACK = 1'b1;
    step();
    releaseDACK = 1'b0;
    chk("mask_fixed_rot", 32'(dut.rotPtr), 32'd1);
    maskIn = 4'b1111; DREQ = 4'b1111;
    step();
    step();
    checkIdle("mask_all");
    chk("mask_all_state", 32'(dut.state), 32'(IDLE));

    // Abort keeps rotPtr; release together with abort advances it
    maskIn = 4'b0000; priorityType = 1'b1; DREQ = 4'b0010;
    expectGrant(32'b0010, 1);
    step();
    checkGrant("abort_g", 32'(DACK), 32'(grantChannel), grantValid);
    assertDACK = 1'b0;
    step();
    checkIdle("abort");
    chk("abort_rot", 32'(dut.rotPtr), 32'd1);
    assertDACK = 1'b1;
    expectGrant(32'b0010, 1);
    step();
    checkGrant("relab_g", 32'(DACK), 32'(grantChannel), grantValid);
    assertDACK = 1'b0; releaseDACK = 1'b1;
    step();
    checkIdle("relab");
    chk("relab_rot", 32'(dut.rotPtr), 32'd2);

    // Release while idle is ignored
    step();
    releaseDACK = 1'b0;
    chk("idle_rel_rot", 32'(dut.rotPtr), 32'd2);
    checkIdle("idle_rel");

    // priorityType change while granted is not picked up by the release
    assertDACK = 1'b1; priorityType = 1'b0; DREQ = 4'b1100;
    expectGrant(32'b0100, 2);
    step();
    checkGrant("mode_g", 32'(DACK), 32'(grantChannel), grantValid);
    priorityType = 1'b1; DREQ = 4'b0001; maskIn = 4'b0100;
    step();
    chk("mode_hold", 32'(DACK), 32'b0100);
    maskIn = 4'b0000; DREQ = 4'b0000; releaseDACK = 1'b1;
    step();
    releaseDACK = 1'b0;
    chk("mode_rot", 32'(dut.rotPtr), 32'd2);

    // Async reset mid-grant
    DREQ = 4'b1000;
    expectGrant(32'b1000, 3);
    step();
    checkGrant("pre_rst", 32'(DACK), 32'(grantChannel), grantValid);
    #2 RESET = 1'b1;
    #1;
    checkIdle("async_rst");
    chk("async_rot", 32'(dut.rotPtr), 32'd0);
    chk("async_state", 32'(dut.state), 32'(IDLE));
    RESET = 1'b0; assertDACK = 1'b0; DREQ = 4'b0000;
    step();

    // Five channels: rotPtr wraps 4 -> 0 with explicit modulo
    assert5 = 1'b1; prio5 = 1'b1; DREQ5 = 5'b10000;
    expectGrant(32'b10000, 4);
    step();
    checkGrant("n5_c4", 32'(DACK5), 32'(grantChannel5), grantValid5);
    DREQ5 = 5'b11111; release5 = 1'b1;
    step();
    release5 = 1'b0;
    chk("n5_gap", 32'(DACK5), 32'd0);
    chk("n5_wrap", 32'(dut5.rotPtr), 32'd0);
    expectGrant(32'b00001, 0);
    step();
    checkGrant("n5_c0", 32'(DACK5), 32'(grantChannel5), grantValid5);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Parametrised DREQ/DACK arbiter. Next generation of the DMA controller's channel priority logic.
- Supports NUM_CH channels, per-channel masking, and fixed or rotating priority.
- Rotation pointer is registered and only advances at end of service.
- Grant is held stable for the whole service period.
- Sits between the bus-side DREQ/DACK pins and the DMA timing/control FSM; the FSM issues the grant request and the end-of-service strobe.

Parameters:
- NUM_CH, 4, number of DMA channels (minimum 2).
- CH_W, $clog2(NUM_CH), channel index width (derived; not overridden).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- DREQ  input  NUM_CH  channel requests, active-high, level.
- maskIn  input  NUM_CH  per-channel mask; 1 = channel ignored.
- priorityType  input  1  0 = fixed priority, 1 = rotating priority.
- assertDACK  input  1  control FSM permits arbitration and grant hold.
- releaseDACK  input  1  end-of-service strobe (TC/EOP), one cycle.
- DACK  output  NUM_CH  one-hot grant, registered.
- grantValid  output  1  high while DACK is non-zero.
- grantChannel  output  CH_W  index of the granted channel; valid when grantValid is high.

Behaviour:
- Reset (async, immediate): DACK=0, grantValid=0, grantChannel=0, state=IDLE, rotPtr=0.
- Eligible requests: eligible = DREQ & ~maskIn.
- State IDLE: if assertDACK is high and eligible is non-zero, pick a winner, register DACK/grantChannel/grantValid on the next CLK edge, and go to GRANTED.
  - Latency is 1 cycle from a sampled request to DACK.
- Fixed priority (priorityType=0): channel 0 highest, NUM_CH-1 lowest; rotPtr is ignored.
- Rotating priority (priorityType=1): rotPtr is the highest-priority index. Search order is rotPtr, rotPtr+1, … modulo NUM_CH.
- priorityType is sampled only in IDLE. Changing it during GRANTED has no effect until the next arbitration. rotPtr is retained across mode changes.
- State GRANTED: DACK holds its value regardless of changes on DREQ, maskIn or priorityType.
- GRANTED -> IDLE on releaseDACK=1.
  - DACK clears on the next edge.
  - In rotating mode, rotPtr becomes (grantChannel+1) mod NUM_CH, so the served channel becomes lowest priority.
- GRANTED -> IDLE on assertDACK=0 without releaseDACK (abort).
  - DACK clears on the next edge.
  - rotPtr is unchanged.
- releaseDACK and assertDACK=0 in the same cycle are treated as a release (rotPtr advances).
- releaseDACK while in IDLE is ignored.
- Back-to-back grants: DACK is low for at least 1 cycle between grants. Re-arbitration is never done in the release cycle.
- rotPtr wrap-around: NUM_CH-1 followed by +1 gives 0.
- For non-power-of-two NUM_CH, the modulo is explicit, not a bit truncation.
- Invariants:
  - DACK is always one-hot or zero.
  - grantValid == |DACK.
  - DACK never changes while in GRANTED.

Optional Feature:
- Macro: DMA_ARB_DREQ_SYNC_EN.
- Defined: DREQ passes through a 2-flop synchronizer (reset to 0) before masking. DREQ-to-DACK latency becomes 3 cycles.
- Undefined: DREQ is used directly; latency is 1 cycle.
- All other behaviour is identical in both builds.

Decomposition:
- Package dma_arb_pkg holds:
  - enum arb_state_e {IDLE, GRANTED}
  - enum prio_type_e {PRIO_FIXED=0, PRIO_ROTATE=1}
  - constant DEFAULT_NUM_CH=4
- Sub-module dma_prio_pick: purely combinational picker.
  - Inputs: eligible, start index, mode.
  - Outputs: found, index.
  - Instantiated once; the fixed mode uses start index 0.

Test Plan:
- Fixed priority: DREQ=4'b1010, assertDACK=1 -> DACK=4'b0010 after 1 cycle, grantChannel=1; DACK holds while DREQ changes to 4'b1000.
- Rotating priority: grant channel 2, pulse releaseDACK, DREQ=4'b1111 -> rotPtr=3, next DACK=4'b1000 after a ≥1-cycle gap; repeat to check wrap to channel 0.
- Masking: DREQ=4'b0011, maskIn=4'b0001 -> DACK=4'b0010; all requests masked -> DACK stays 0 and state stays IDLE.
- Abort: in GRANTED on channel 1, drop assertDACK -> DACK=0 next cycle, rotPtr unchanged; a release in the same cycle instead advances rotPtr.
- Async reset: RESET pulsed mid-grant between clock edges -> DACK=0 immediately and rotPtr=0; NUM_CH=5 regression checks rotPtr wrapping 4->0.
